sclk_edge_rx: RTL

- Receiving end of the slow-clock path: takes a slow or asynchronous level such as a divided `sclk` or a board pushbutton, and brings it into the `clk` domain.
- Synchronizes the input, debounces it and generates edge pulses.
- Provides downstream logic (single-step control, display refresh, LED/test counters) with a clean level, one-cycle rise/fall strobes and a rising-edge count.
- Nothing downstream ever uses the slow signal as a clock.

---
 rtl/sclk_edge_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sclk_edge_rx.sv
// Brings a slow/asynchronous level (divided sclk, pushbutton) into the clk domain as a clean level.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk edges from input change to level/strobe update.
// No backpressure: free-running receiver, strobes are single-cycle and must be consumed when seen.
module sclk_edge_rx #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sig_in,
   input  logic                 cnt_clr,
   output logic                 level,
   output logic                 rise,
   output logic                 fall,
   output logic [CNT_WIDTH-1:0] edge_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_LOW      = 2'd0;
   localparam logic [1:0] ST_RISE_CHK = 2'd1;
   localparam logic [1:0] ST_HIGH     = 2'd2;
   localparam logic [1:0] ST_FALL_CHK = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [CNT_WIDTH-1:0]   edge_count_q, edge_count_d;
   logic                   s;
   logic                   accept_rise;

   // Only the last synchronizer stage is allowed to reach the debounce logic.
   assign s = sync_q[SYNC_STAGES-1];

   // Shift the raw input through the synchronizer chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
   end

   // Debounce FSM: a new value must be seen on DEBOUNCE_CYCLES consecutive edges to be accepted.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      accept_rise = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = ST_RISE_CHK;
               cnt_d   = CW'(1);
            end
         end
         ST_RISE_CHK: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_HIGH;
               level_d     = 1'b1;
               rise_d      = 1'b1;
               accept_rise = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = ST_FALL_CHK;
               cnt_d   = CW'(1);
            end
         end
         ST_FALL_CHK: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // Edge counter: clear takes effect first so a coincident rise leaves the count at 1.
   always_comb begin
      edge_count_d = edge_count_q;
      if (cnt_clr) begin
         edge_count_d = '0;
      end
      if (accept_rise) begin
         edge_count_d = edge_count_d + CNT_WIDTH'(1);
      end
   end

   // State registers; async reset drives every output to 0 immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q       <= '0;
         state_q      <= ST_LOW;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         edge_count_q <= '0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         edge_count_q <= edge_count_d;
      end
   end

   assign level      = level_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign edge_count = edge_count_q;

endmodule
